// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-side consumer re-presenting words as a valid/ready stream
//
// Issues reads to a synchronous FIFO with 1-cycle read latency, captures the
// returned words into a small circular output buffer and presents the buffer
// head as a valid/ready stream.
//
// Ports:
//   clk            clock, all logic on posedge
//   rst            synchronous active-high reset
//   enable         1: issue FIFO reads; 0: stop new reads, buffer still drains
//   fifo_empty     FIFO empty flag
//   fifo_data_out  FIFO read data, valid the cycle after fifo_rd_en
//   fifo_underflow FIFO underflow flag
//   fifo_rd_en     FIFO read request
//   m_valid        stream word valid
//   m_data         stream word (buffer head)
//   m_ready        sink accepts word when m_valid && m_ready
//   word_count     completed stream handshakes, wraps
//   underflow_err  sticky underflow indication, cleared by rst
module fifo_stream_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int OBUF_DEPTH = 3,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  underflow_err
);

  localparam int PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int OCC_W = $clog2(OBUF_DEPTH + 1);

  logic [FIFO_WIDTH-1:0] buf_q [OBUF_DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  inflight_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  err_q;
  logic                  push;
  logic                  pop;

  // Credit check counts the in-flight word as already occupying a slot, so a
  // returning read always has room and m_ready never reaches fifo_rd_en.
  always_comb begin
    fifo_rd_en = !rst && enable && !fifo_empty &&
                 (({1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_q}) < (OCC_W + 1)'(OBUF_DEPTH));
  end

  always_comb begin
    m_valid       = (occ_q != '0);
    m_data        = buf_q[head_q];
    word_count    = count_q;
    underflow_err = err_q;
    push          = inflight_q && !fifo_underflow;
    pop           = m_valid && m_ready;

    head_d = head_q;
    if (pop) begin
      head_d = (head_q == PTR_W'(OBUF_DEPTH - 1)) ? '0 : head_q + 1'b1;
    end
    tail_d = tail_q;
    if (push) begin
      tail_d = (tail_q == PTR_W'(OBUF_DEPTH - 1)) ? '0 : tail_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      inflight_q <= fifo_rd_en;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      if (push) begin
        buf_q[tail_q] <= fifo_data_out;
      end
      if (pop) begin
        count_q <= count_q + 1'b1;
      end
      // Any underflow report latches, whether or not a read was in flight.
      if (fifo_underflow) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (occ_q <= OCC_W'(OBUF_DEPTH));
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;
  localparam int W  = 16;
  localparam int D  = 3;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [W-1:0]  fifo_data_out = '0;
  logic          fifo_underflow = 1'b0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          m_ready = 1'b0;
  logic [CW-1:0] word_count;
  logic          underflow_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];
  int           hs_log[$];
  int           cyc_n = 0;
  int           rd_pulses = 0;
  int           delivered = 0;
  int           first_rd = -1;
  int           first_valid = -1;
  int           pushed = 0;
  int           budget = 0;
  bit           uf_arm = 1'b0;
  bit           occ_chk = 1'b0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;

  fifo_stream_reader #(.FIFO_WIDTH(W), .OBUF_DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .fifo_underflow(fifo_underflow),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .word_count(word_count), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: observe at negedge, then model the FIFO read port after posedge.
  task automatic cyc();
    bit rd;
    bit was_rst;
    logic [W-1:0] w;
    @(negedge clk);
    rd = (fifo_rd_en === 1'b1);
    was_rst = rst;
    if (occ_chk) chk("occ_bound", 64'(exp_q.size() <= D), 64'd1);
    if (prev_stall && !was_rst) begin
      chk("hold_valid", 64'(m_valid), 64'd1);
      chk("hold_data", 64'(m_data), 64'(prev_data));
    end
    if (rd) begin
      rd_pulses++;
      if (first_rd < 0) first_rd = cyc_n;
    end
    if (!was_rst && m_valid === 1'b1 && first_valid < 0) first_valid = cyc_n;
    if (!was_rst && m_valid === 1'b1 && m_ready) begin
      if (exp_q.size() == 0) chk("spurious_word", 64'(m_data), 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("stream_data", 64'(m_data), 64'(exp_q.pop_front()));
      delivered++;
      hs_log.push_back(cyc_n);
    end
    prev_stall = !was_rst && (m_valid === 1'b1) && !m_ready;
    prev_data  = m_data;
    @(posedge clk);
    #1;
    cyc_n++;
    fifo_underflow = 1'b0;
    if (was_rst) begin
      exp_q.delete();
      delivered = 0;
    end
    if (rd && fq.size() > 0) begin
      w = fq.pop_front();
      fifo_data_out = w;
      if (uf_arm) begin
        fifo_underflow = 1'b1;
        uf_arm = 1'b0;
      end else begin
        exp_q.push_back(w);
      end
    end
    fifo_empty = (fq.size() == 0);
    #1;
  endtask

  task automatic start();
    rst = 1'b1;
    enable = 1'b0;
    m_ready = 1'b0;
    cyc();
    rst = 1'b0;
    fq.delete();
    fifo_empty = 1'b1;
    uf_arm = 1'b0;
    rd_pulses = 0;
    first_rd = -1;
    first_valid = -1;
    hs_log.delete();
  endtask

  task automatic fill(input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(base + W'(i));
    fifo_empty = (fq.size() == 0);
  endtask

  initial begin
    // Reset with a non-empty FIFO and enable high
    fill(16'hAAAA, 1);
    enable = 1'b1;
    rst = 1'b1;
    repeat (2) cyc();
    chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_word_count", 64'(word_count), 64'd0);
    chk("rst_underflow_err", 64'(underflow_err), 64'd0);
    chk("rst_no_reads", 64'(rd_pulses), 64'd0);

    // Streaming at full rate
    start();
    fill(16'h0001, 8);
    enable = 1'b1;
    m_ready = 1'b1;
    repeat (14) cyc();
    chk("stream_latency", 64'(first_valid - first_rd), 64'd2);
    chk("stream_count", 64'(hs_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < hs_log.size()) chk("stream_consecutive", 64'(hs_log[i] - hs_log[0]), 64'(i));
    end
    chk("stream_word_count", 64'(word_count), 64'd8);

    // Backpressure: only the buffer's worth of credits may be spent
    start();
    fill(16'h0001, 8);
    enable = 1'b1;
    m_ready = 1'b0;
    repeat (10) cyc();
    chk("bp_rd_pulses", 64'(rd_pulses), 64'd3);
    chk("bp_m_valid", 64'(m_valid), 64'd1);
    chk("bp_m_data", 64'(m_data), 64'h0001);
    m_ready = 1'b1;
    budget = 0;
    while (delivered < 8 && budget < 40) begin
      cyc();
      budget++;
    end
    chk("bp_delivered", 64'(delivered), 64'd8);
    chk("bp_word_count", 64'(word_count), 64'd8);
    chk("bp_fifo_drained", 64'(fq.size()), 64'd0);

    // Random backpressure and random FIFO fill
    start();
    enable = 1'b1;
    occ_chk = 1'b1;
    pushed = 0;
    budget = 0;
    while (delivered < 1000 && budget < 8000) begin
      m_ready = ($urandom % 2) == 0;
      if (pushed < 1000 && ($urandom % 4) != 0) begin
        fq.push_back(W'($urandom));
        pushed++;
        fifo_empty = 1'b0;
      end
      cyc();
      budget++;
    end
    occ_chk = 1'b0;
    chk("rand_delivered", 64'(delivered), 64'd1000);
    chk("rand_word_count", 64'(word_count), 64'd1000);
    chk("rand_leftover", 64'(exp_q.size()), 64'd0);

    // Underflow on the first read drops that word
    start();
    fill(16'h0100, 5);
    enable = 1'b1;
    m_ready = 1'b1;
    uf_arm = 1'b1;
    repeat (12) cyc();
    chk("uf_err_set", 64'(underflow_err), 64'd1);
    chk("uf_delivered", 64'(delivered), 64'd4);
    chk("uf_word_count", 64'(word_count), 64'd4);
    repeat (5) cyc();
    chk("uf_err_sticky", 64'(underflow_err), 64'd1);
    start();
    chk("uf_err_cleared", 64'(underflow_err), 64'd0);
    fifo_underflow = 1'b1;
    cyc();
    chk("uf_err_idle_pulse", 64'(underflow_err), 64'd1);

    // enable drop with a read in flight, then reset with a partly full buffer
    start();
    fill(16'h0200, 6);
    enable = 1'b1;
    m_ready = 1'b0;
    repeat (2) cyc();
    enable = 1'b0;
    repeat (4) cyc();
    chk("dis_rd_pulses", 64'(rd_pulses), 64'd2);
    chk("dis_m_valid", 64'(m_valid), 64'd1);
    chk("dis_m_data", 64'(m_data), 64'h0200);
    m_ready = 1'b1;
    repeat (2) cyc();
    m_ready = 1'b0;
    chk("dis_inflight_delivered", 64'(delivered), 64'd2);
    enable = 1'b1;
    repeat (2) cyc();
    enable = 1'b0;
    repeat (2) cyc();
    chk("mid_rd_pulses", 64'(rd_pulses), 64'd4);
    chk("mid_m_valid", 64'(m_valid), 64'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_m_data", 64'(m_data), 64'd0);
    m_ready = 1'b1;
    repeat (3) cyc();
    chk("mid_rst_empty", 64'(m_valid), 64'd0);
    chk("mid_rst_word_count", 64'(word_count), 64'd0);
    enable = 1'b1;
    repeat (6) cyc();
    chk("mid_resume_delivered", 64'(delivered), 64'd2);
    chk("mid_resume_word_count", 64'(word_count), 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
